// File: rtl/blob_ram_sched_pkg.sv
// Shared definitions for the blob statistics RAM scheduler: default widths,
// record field offsets and scanner state encoding.
package blob_ram_sched_pkg;

    localparam int BLOB_AW = 11;
    localparam int BLOB_NW = 19;
    localparam int BLOB_CW = 10;
    localparam int BLOB_FD = 4;
    localparam int BLOB_RW = BLOB_NW + 4 * BLOB_CW;

    // Record layout {npix, x0, y0, xn, yn}, yn in the low bits
    localparam int YN_LSB   = 0;
    localparam int XN_LSB   = BLOB_CW;
    localparam int Y0_LSB   = 2 * BLOB_CW;
    localparam int X0_LSB   = 3 * BLOB_CW;
    localparam int NPIX_LSB = 4 * BLOB_CW;

    // Labels 0 and 1 are reserved; the scan always starts at label 2
    localparam int FIRST_LABEL = 2;

    // Scanner state encoding
    localparam int         ST_W    = 3;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD   = 3'd1;
    localparam logic [2:0] ST_WT   = 3'd2;
    localparam logic [2:0] ST_OUT  = 3'd3;
    localparam logic [2:0] ST_CLR  = 3'd4;
    localparam logic [2:0] ST_DONE = 3'd5;

endpackage

// File: rtl/blob_sync_fifo.sv
// Small synchronous FIFO buffering merge-writer records until the RAM port
// is free. A push while full is ignored, even if a pop happens that cycle.
module blob_sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          do_push_s, do_pop_s;

    assign full      = (count_q == (PW + 1)'(DEPTH));
    assign empty     = (count_q == '0);
    assign do_push_s = push & ~full;
    assign do_pop_s  = pop & ~empty;
    assign rdata     = mem_q[rd_ptr_q];

    // Next pointer and occupancy values
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) begin
            wr_ptr_d = wr_ptr_q + PW'(1'b1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (do_pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1'b1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + (PW + 1)'(1'b1);
            2'b01:   count_d = count_q - (PW + 1)'(1'b1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/blob_ram_sched.sv
// Arbitrates one single-port statistics RAM between the pixel updater
// (highest priority, zero latency), a buffered merge writer, and an
// end-of-frame scanner that reads out and clears labels 2..last_label.
module blob_ram_sched
    import blob_ram_sched_pkg::*;
#(
    parameter int AW = BLOB_AW,
    parameter int NW = BLOB_NW,
    parameter int CW = BLOB_CW,
    parameter int FD = BLOB_FD
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 p_wr,
    input  logic [AW-1:0]        p_addr,
    input  logic [NW+4*CW-1:0]   p_data,
    input  logic                 m_wr,
    input  logic [AW-1:0]        m_addr,
    input  logic [NW+4*CW-1:0]   m_data,
    output logic                 m_full,
    output logic                 m_ovf,
    input  logic                 frame_end,
    input  logic [AW-1:0]        last_label,
    output logic                 o_valid,
    output logic [AW-1:0]        o_addr,
    output logic [NW+4*CW-1:0]   o_data,
    input  logic                 o_ready,
    output logic                 busy,
    output logic                 scan_done,
    output logic [AW-1:0]        ram_addr,
    output logic [NW+4*CW-1:0]   ram_wdata,
    output logic                 ram_wr,
    output logic                 ram_rd,
    input  logic [NW+4*CW-1:0]   ram_rdata
);
    localparam int RW = NW + 4 * CW;

    logic [ST_W-1:0] state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [AW-1:0]   last_q, last_d;
    logic [AW-1:0]   o_addr_q, o_addr_d;
    logic [RW-1:0]   o_data_q, o_data_d;
    logic            m_ovf_q, m_ovf_d;

    logic            fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s;
    logic [AW+RW-1:0] fifo_head_s;
    logic            scan_gnt_s, scan_rd_s, scan_wr_s;

    // Drop is decided against the full flag at the start of the cycle
    assign fifo_push_s = m_wr & ~fifo_full_s;
    assign fifo_pop_s  = ~reset & ~p_wr & ~fifo_empty_s;
    assign scan_gnt_s  = ~p_wr & fifo_empty_s;

    blob_sync_fifo #(
        .W     (AW + RW),
        .DEPTH (FD)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push_s),
        .wdata ({m_addr, m_data}),
        .pop   (fifo_pop_s),
        .rdata (fifo_head_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    assign m_full    = fifo_full_s;
    assign m_ovf     = m_ovf_q;
    assign o_valid   = (state_q == ST_OUT);
    assign o_addr    = o_addr_q;
    assign o_data    = o_data_q;
    assign busy      = (state_q != ST_IDLE);
    assign scan_done = (state_q == ST_DONE);

    // Scanner next-state logic and overflow flag
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        last_d    = last_q;
        o_addr_d  = o_addr_q;
        o_data_d  = o_data_q;
        scan_rd_s = 1'b0;
        scan_wr_s = 1'b0;
        m_ovf_d   = m_ovf_q | (m_wr & fifo_full_s);
        case (state_q)
            ST_IDLE: begin
                if (frame_end) begin
                    if (last_label >= AW'(FIRST_LABEL)) begin
                        last_d  = last_label;
                        addr_d  = AW'(FIRST_LABEL);
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                if (scan_gnt_s) begin
                    scan_rd_s = 1'b1;
                    state_d   = ST_WT;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_WT: begin
                o_data_d = ram_rdata;
                o_addr_d = addr_q;
                state_d  = ST_OUT;
            end
            ST_OUT: begin
                if (o_ready) begin
                    state_d = ST_CLR;
                end else begin
                    state_d = ST_OUT;
                end
            end
            ST_CLR: begin
                if (scan_gnt_s) begin
                    scan_wr_s = 1'b1;
                    if (addr_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + AW'(1'b1);
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_CLR;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Scanner and flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            last_q   <= '0;
            o_addr_q <= '0;
            o_data_q <= '0;
            m_ovf_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            last_q   <= last_d;
            o_addr_q <= o_addr_d;
            o_data_q <= o_data_d;
            m_ovf_q  <= m_ovf_d;
        end
    end

    // Fixed-priority RAM port mux: pixel updater, then FIFO head, then scanner
    always_comb begin
        ram_addr  = '0;
        ram_wdata = '0;
        ram_wr    = 1'b0;
        ram_rd    = 1'b0;
        if (reset) begin
            ram_wr = 1'b0;
        end else if (p_wr) begin
            ram_addr  = p_addr;
            ram_wdata = p_data;
            ram_wr    = 1'b1;
        end else if (!fifo_empty_s) begin
            ram_addr  = fifo_head_s[AW+RW-1:RW];
            ram_wdata = fifo_head_s[RW-1:0];
            ram_wr    = 1'b1;
        end else if (scan_rd_s) begin
            ram_addr = addr_q;
            ram_rd   = 1'b1;
        end else if (scan_wr_s) begin
            ram_addr = addr_q;
            ram_wr   = 1'b1;
        end else begin
            ram_wr = 1'b0;
        end
    end

endmodule

// File: tb/tb_blob_ram_sched.sv
// Scoreboard bench for blob_ram_sched: a behavioural RAM, a reference model of
// the merge queue / scan sequence / statistics memory, and separate monitors.
module tb_blob_ram_sched;
    localparam int AW = 11;
    localparam int NW = 19;
    localparam int CW = 10;
    localparam int FD = 4;
    localparam int RW = NW + 4 * CW;

    logic          clk = 1'b0;
    logic          reset;
    logic          p_wr, m_wr, frame_end, o_ready;
    logic [AW-1:0] p_addr, m_addr, last_label;
    logic [RW-1:0] p_data, m_data;
    logic          m_full, m_ovf, o_valid, busy, scan_done, ram_wr, ram_rd;
    logic [AW-1:0] o_addr, ram_addr;
    logic [RW-1:0] o_data, ram_wdata, ram_rdata;

    blob_ram_sched #(.AW(AW), .NW(NW), .CW(CW), .FD(FD)) dut (
        .clk(clk), .reset(reset),
        .p_wr(p_wr), .p_addr(p_addr), .p_data(p_data),
        .m_wr(m_wr), .m_addr(m_addr), .m_data(m_data),
        .m_full(m_full), .m_ovf(m_ovf),
        .frame_end(frame_end), .last_label(last_label),
        .o_valid(o_valid), .o_addr(o_addr), .o_data(o_data), .o_ready(o_ready),
        .busy(busy), .scan_done(scan_done),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wr(ram_wr), .ram_rd(ram_rd),
        .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int n_rec = 0;
    int n_done = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    // Behavioural single-port RAM (the DUT's memory)
    logic [RW-1:0] ram_mem [0:(1<<AW)-1];
    // Reference statistics memory predicted from the specification rules
    logic [RW-1:0] ref_mem [0:(1<<AW)-1];

    initial begin
        for (int i = 0; i < (1 << AW); i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
    end

    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
        if (ram_rd) ram_rdata <= ram_mem[ram_addr];
    end

    // Reference model state
    typedef struct { bit is_clr; logic [AW-1:0] a; } sop_t;
    logic [AW+RW-1:0] mq[$];     // accepted merge writes awaiting the RAM
    sop_t             sq[$];     // remaining scanner reads/clears in order
    logic [AW+RW-1:0] recq[$];   // records the consumer should receive
    bit exp_ovf = 1'b0;
    bit exp_busy = 1'b0;
    bit done_due = 1'b0;
    bit rec_accepted = 1'b0;

    // RAM-port monitor: predicts each cycle's access from the priority rules
    always @(negedge clk) begin : ram_mon
        bit full0, busy0, done_now, ok;
        logic [AW-1:0] ea;
        if (reset) begin
            chk("rst_ram", {ram_wr, ram_rd}, 2'b00);
            mq.delete(); sq.delete(); recq.delete();
            exp_ovf = 1'b0; exp_busy = 1'b0; done_due = 1'b0; rec_accepted = 1'b0;
        end else begin
            full0 = (mq.size() == FD);
            busy0 = exp_busy;
            done_now = done_due;
            done_due = 1'b0;
            chk("m_full", m_full, full0);
            chk("m_ovf", m_ovf, exp_ovf);
            chk("busy", busy, busy0);
            chk("scan_done", scan_done, done_now);
            if (scan_done) n_done++;
            if (p_wr) begin
                chk("p_port", {ram_wr, ram_rd, ram_addr, ram_wdata}, {2'b10, p_addr, p_data});
                ref_mem[p_addr] = p_data;
            end else if (mq.size() != 0) begin
                chk("m_port", {ram_wr, ram_rd, ram_addr, ram_wdata}, {2'b10, mq[0]});
                ref_mem[mq[0][AW+RW-1:RW]] = mq[0][RW-1:0];
                void'(mq.pop_front());
            end else if (ram_rd && !ram_wr) begin
                ea = (sq.size() != 0) ? sq[0].a : '1;
                ok = (sq.size() != 0) && !sq[0].is_clr && (sq[0].a == ram_addr);
                chk("scan_rd", {ok, ram_addr}, {1'b1, ea});
                if (ok) begin
                    recq.push_back({ram_addr, ref_mem[ram_addr]});
                    void'(sq.pop_front());
                end
            end else if (ram_wr && !ram_rd) begin
                ea = (sq.size() != 0) ? sq[0].a : '1;
                ok = (sq.size() != 0) && sq[0].is_clr && (sq[0].a == ram_addr)
                     && (ram_wdata == '0) && rec_accepted;
                chk("scan_clr", {ok, ram_addr}, {1'b1, ea});
                if (ok) begin
                    ref_mem[ram_addr] = '0;
                    rec_accepted = 1'b0;
                    void'(sq.pop_front());
                    if (sq.size() == 0) done_due = 1'b1;
                end
            end else if (ram_wr && ram_rd) begin
                chk("ram_excl", {ram_wr, ram_rd}, 2'b01);
            end
            if (m_wr) begin
                if (full0) exp_ovf = 1'b1;
                else mq.push_back({m_addr, m_data});
            end
            if (done_now) exp_busy = 1'b0;
            if (frame_end && !busy0) begin
                exp_busy = 1'b1;
                if (last_label >= 2) begin
                    for (int k = 2; k <= int'(last_label); k++) begin
                        sq.push_back('{is_clr: 1'b0, a: AW'(k)});
                        sq.push_back('{is_clr: 1'b1, a: AW'(k)});
                    end
                end else begin
                    done_due = 1'b1;
                end
            end
        end
    end

    // Output monitor: pops the expected record whenever one is accepted
    bit            hold_q = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [RW-1:0] hold_data;
    always @(negedge clk) begin : out_mon
        if (reset) begin
            hold_q = 1'b0;
        end else begin
            if (hold_q) chk("o_hold", {o_valid, o_addr, o_data}, {1'b1, hold_addr, hold_data});
            if (o_valid) begin
                if (recq.size() == 0) begin
                    chk("o_unexpected", o_valid, 1'b0);
                end else if (o_ready) begin
                    chk("o_rec", {o_addr, o_data}, recq[0]);
                    void'(recq.pop_front());
                    rec_accepted = 1'b1;
                    n_rec++;
                end
            end
            hold_q = o_valid && !o_ready;
            hold_addr = o_addr;
            hold_data = o_data;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        p_wr = 1'b0; m_wr = 1'b0; frame_end = 1'b0;
    endtask

    task automatic pulse_fe(input int lab);
        frame_end = 1'b1;
        last_label = AW'(lab);
        cyc();
        frame_end = 1'b0;
    endtask

    task automatic wait_valid(input int budget);
        int k = 0;
        while (!o_valid && k < budget) begin cyc(); k++; end
        chk("wait_valid", o_valid, 1'b1);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while ((busy || sq.size() != 0 || mq.size() != 0) && k < budget) begin cyc(); k++; end
        chk("wait_idle", {busy, sq.size() != 0}, 2'b00);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int r0, d0;
        reset = 1'b1; o_ready = 1'b0; last_label = '0;
        p_addr = '0; m_addr = '0; p_data = '0; m_data = '0;
        idle_inputs();
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        chk("rst_state", {m_ovf, m_full, o_valid, busy, scan_done, ram_wr, ram_rd, o_addr, o_data},
            '0);

        // P and M in the same cycle: P wins now, M lands next cycle
        p_wr = 1'b1; p_addr = AW'(5); p_data = RW'({$urandom(), $urandom()});
        m_wr = 1'b1; m_addr = AW'(6); m_data = RW'({$urandom(), $urandom()});
        #1;
        chk("s1_p_first", {ram_wr, ram_addr, ram_wdata}, {1'b1, AW'(5), p_data});
        cyc();
        idle_inputs();
        #1;
        chk("s1_m_next", {ram_wr, ram_addr}, {1'b1, AW'(6)});
        cyc();

        // FIFO starved by continuous P writes: fifth merge write is dropped
        for (int i = 0; i < 8; i++) begin
            p_wr = 1'b1; p_addr = AW'(20 + i); p_data = RW'({$urandom(), $urandom()});
            m_wr = (i < 5); m_addr = AW'(40 + i); m_data = RW'({$urandom(), $urandom()});
            if (i == 3) chk("s2_not_full", m_full, 1'b0);
            if (i == 4) chk("s2_full", m_full, 1'b1);
            if (i == 5) chk("s2_ovf", m_ovf, 1'b1);
            cyc();
        end
        idle_inputs();
        repeat (6) cyc();
        chk("s2_drained", m_full, 1'b0);

        // Full scan of labels 2..4 with the consumer always ready
        for (int a = 2; a <= 4; a++) begin
            p_wr = 1'b1; p_addr = AW'(a); p_data = RW'({$urandom(), $urandom()});
            cyc();
        end
        idle_inputs();
        o_ready = 1'b1;
        r0 = n_rec; d0 = n_done;
        pulse_fe(4);
        wait_idle(100);
        cyc();
        chk("s3_records", n_rec - r0, 3);
        chk("s3_done", n_done - d0, 1);

        // Consumer stalls 10 cycles in OUT: data stable, scanner quiet
        o_ready = 1'b0;
        p_wr = 1'b1; p_addr = AW'(2); p_data = RW'({$urandom(), $urandom()});
        cyc();
        idle_inputs();
        pulse_fe(2);
        wait_valid(20);
        repeat (10) begin
            chk("s4_no_scan_access", {ram_wr, ram_rd}, 2'b00);
            cyc();
        end
        o_ready = 1'b1;
        wait_idle(50);
        cyc();

        // last_label below the first label: immediate done, no RAM traffic
        pulse_fe(1);
        chk("s5_done_2nd", {scan_done, busy, ram_wr, ram_rd}, 4'b1100);
        cyc();
        chk("s5_back_idle", {scan_done, busy}, 2'b00);

        // frame_end during a scan is ignored
        o_ready = 1'b0;
        r0 = n_rec;
        pulse_fe(3);
        wait_valid(20);
        pulse_fe(9);
        o_ready = 1'b1;
        wait_idle(100);
        cyc();
        chk("s5_ignored", n_rec - r0, 2);

        // Reset while presenting a record abandons the scan
        o_ready = 1'b0;
        pulse_fe(5);
        wait_valid(20);
        reset = 1'b1;
        #1;
        chk("s6_no_clr", {ram_wr, ram_rd}, 2'b00);
        cyc();
        reset = 1'b0;
        #1;
        chk("s6_after_rst", {busy, o_valid, m_ovf, scan_done}, 4'b0000);
        repeat (3) cyc();

        // Randomized traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            p_wr = ($urandom_range(99) < 30);
            p_addr = AW'($urandom_range(7));
            p_data = RW'({$urandom(), $urandom()});
            m_wr = ($urandom_range(99) < 30);
            m_addr = AW'($urandom_range(7));
            m_data = RW'({$urandom(), $urandom()});
            o_ready = ($urandom_range(99) < 70);
            frame_end = ($urandom_range(99) < 3);
            last_label = AW'($urandom_range(6));
            cyc();
        end
        idle_inputs();
        o_ready = 1'b1;
        wait_idle(500);
        repeat (3) cyc();
        chk("end_queues", {mq.size() != 0, sq.size() != 0, recq.size() != 0}, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/blob_ram_sched.md
BLOB_RAM_SCHED -- requirements
Module: blob_ram_sched

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, named clk and reset as elsewhere in the codebase.
REQ-002 The block SHALL have these parameters (name, default, meaning):
- AW, 11, label/RAM address width.
- NW, 19, pixel-count width.
- CW, 10, coordinate width.
- FD, 4, merge FIFO depth (power of 2).
REQ-003 The block SHALL have these ports (name, direction, width, meaning), all data fields ordered {npix,x0,y0,xn,yn} (RW = NW+4*CW):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- p_wr, p_addr, p_data; in; 1, AW, RW; pixel-updater write, never stalled.
- m_wr, m_addr, m_data; in; 1, AW, RW; merge-writer write into FIFO.
- m_full, out, 1, FIFO full.
- m_ovf, out, 1, sticky: a merge write was dropped.
- frame_end, in, 1, start-scan pulse.
- last_label, in, AW, highest label allocated this frame.
- o_valid, o_addr, o_data; out; 1, AW, RW; scanned record.
- o_ready, in, 1, consumer accepts record.
- busy, out, 1, scan in progress.
- scan_done, out, 1, one-cycle pulse at end of scan.
- ram_addr, ram_wdata, ram_wr, ram_rd; out; AW, RW, 1, 1; single-port statistics RAM.
- ram_rdata, in, RW, valid the cycle after ram_rd.

Function
REQ-004 The RAM port SHALL be granted each cycle by fixed priority: P > M FIFO head > scanner; at most one of ram_wr/ram_rd SHALL be high per cycle.
REQ-005 A p_wr SHALL drive ram_addr/ram_wdata/ram_wr combinationally in the same cycle (zero latency).
REQ-006 m_wr with the FIFO not full SHALL enqueue; m_wr when full SHALL be dropped and set m_ovf until reset; simultaneous enqueue and dequeue when full SHALL be treated as full (drop).
REQ-007 The FIFO head SHALL be written to RAM in the first cycle without p_wr; minimum enqueue-to-RAM latency SHALL be 1 cycle.
REQ-008 The scanner FSM SHALL have states IDLE, RD, WT, OUT, CLR, DONE.
REQ-009 From IDLE, on frame_end: if last_label >= 2, SHALL latch last_label, set addr=2 and go to RD; otherwise SHALL go to DONE.
REQ-010 RD SHALL assert ram_rd when granted, then go to WT; while not granted it SHALL remain in RD.
REQ-011 WT SHALL capture ram_rdata into o_data and addr into o_addr, then go to OUT.
REQ-012 OUT SHALL hold o_valid=1 with stable o_addr/o_data until o_ready; on o_valid && o_ready it SHALL go to CLR.
REQ-013 CLR SHALL write an all-zero record to addr when granted; if addr == latched last_label it SHALL go to DONE, else addr+1 and RD.
REQ-014 DONE SHALL pulse scan_done for one cycle and return to IDLE.
REQ-015 busy SHALL be 1 in every state except IDLE; frame_end while busy SHALL be ignored.
REQ-016 P or M writes to an address between its RD and CLR SHALL still be overwritten by the clear (documented hazard, not protected).

Reset
REQ-017 Reset SHALL force FSM=IDLE, FIFO empty, and all outputs to 0 (m_ovf, o_valid, o_addr, o_data, busy, scan_done, ram_*); reset mid-scan SHALL abandon the scan without a clear write.

Structure
REQ-018 The default widths, record field offsets and the FSM state encoding SHALL live in a shared blob package.
REQ-019 The merge FIFO SHALL be one sub-module, blob_sync_fifo (FD x (AW+RW)).

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- P write addr 5 and m_wr addr 6 in the same cycle -> RAM writes 5 that cycle, 6 the next cycle.
- 5 m_wr with FIFO stalled by continuous p_wr -> m_full after 4, fifth dropped, m_ovf=1.
- frame_end, last_label=4, o_ready always 1 -> records 2, 3, 4 output in order, each followed by a zero write, then scan_done.
- o_ready held low 10 cycles in OUT -> o_data stable; no RAM access by the scanner.
- frame_end with last_label=1 -> scan_done on the 2nd cycle, no RAM access; frame_end while busy -> ignored.
- reset asserted in OUT -> next cycle busy=0, o_valid=0, no clear write.
